// File: rtl/fetch_stage.sv
// fetch_stage: program counter, next-PC selection and IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Data,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] ID_RsData,
    input  logic        EX_BranchTaken,
    input  logic [31:0] EX_BranchTarget,
    input  logic        Stall,
    input  logic        IRQ_Raw,
    output logic        IRQ,
    output logic        PC_31,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC_plus4,
    output logic        ID_Valid,
    output logic        Flush_IDEX
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] pc_plus4, jump_tgt, redir_pc;
    logic        redirect, bubble, load;

    // Next-PC priority (branch, stall, ID redirect, sequential) and IF/ID load/hold/bubble choice
    always_comb begin
        pc_plus4   = {pc_q[31], pc_q[30:0] + 31'd4};
        jump_tgt   = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
        redir_pc   = (PCSrc == 3'b100) ? ILLOP_VEC :
                     (PCSrc == 3'b101) ? XADR_VEC  :
                     (PCSrc == 3'b010) ? jump_tgt  : ID_RsData;
        redirect   = id_valid_q && !Stall && (PCSrc inside {3'b010, 3'b011, 3'b100, 3'b101});
        bubble     = EX_BranchTaken || redirect;
        load       = bubble || !Stall;
        pc_d       = EX_BranchTaken ? EX_BranchTarget :
                     Stall          ? pc_q            :
                     redirect       ? redir_pc        : pc_plus4;
        id_instr_d = bubble ? 32'h0000_0000 : load ? IMem_Data : id_instr_q;
        id_pc_d    = load ? pc_q : id_pc_q;
        id_pc4_d   = load ? pc_plus4 : id_pc4_q;
        id_valid_d = bubble ? 1'b0 : load ? 1'b1 : id_valid_q;
    end

    // PC and IF/ID registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_VEC;
            id_instr_q <= 32'h0000_0000;
            id_pc_q    <= RESET_VEC;
            id_pc4_q   <= RESET_VEC + 32'd4;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign IMem_Addr      = pc_q;
    assign ID_Instruction = id_instr_q;
    assign ID_PC          = id_pc_q;
    assign ID_PC_plus4    = id_pc4_q;
    assign ID_Valid       = id_valid_q;
    assign PC_31          = id_pc_q[31];
    assign IRQ            = IRQ_Raw && id_valid_q && !id_pc_q[31] && !Stall;
    assign Flush_IDEX     = EX_BranchTaken;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IMem_Addr, IMem_Data;
    logic [2:0]  PCSrc = 3'b000;
    logic [31:0] ID_RsData = 32'h0;
    logic        EX_BranchTaken = 1'b0;
    logic [31:0] EX_BranchTarget = 32'h0;
    logic        Stall = 1'b0;
    logic        IRQ_Raw = 1'b0;
    logic        IRQ, PC_31, ID_Valid, Flush_IDEX;
    logic [31:0] ID_Instruction, ID_PC, ID_PC_plus4;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
    logic        m_valid;

    fetch_stage dut (
        .clk(clk), .reset(reset), .IMem_Addr(IMem_Addr), .IMem_Data(IMem_Data),
        .PCSrc(PCSrc), .ID_RsData(ID_RsData), .EX_BranchTaken(EX_BranchTaken),
        .EX_BranchTarget(EX_BranchTarget), .Stall(Stall), .IRQ_Raw(IRQ_Raw),
        .IRQ(IRQ), .PC_31(PC_31), .ID_Instruction(ID_Instruction), .ID_PC(ID_PC),
        .ID_PC_plus4(ID_PC_plus4), .ID_Valid(ID_Valid), .Flush_IDEX(Flush_IDEX)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0040) ? 32'h0800_0100 : (a * 32'h9E37_79B1) ^ 32'h2108_0001;
    endfunction

    assign IMem_Data = mem_word(IMem_Addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000;
        m_instr = 32'h0;
        m_idpc = 32'h8000_0000;
        m_idpc4 = 32'h8000_0004;
        m_valid = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " pc"}, IMem_Addr, m_pc);
        check({tag, " instr"}, ID_Instruction, m_instr);
        check({tag, " id_pc"}, ID_PC, m_idpc);
        check({tag, " id_pc4"}, ID_PC_plus4, m_idpc4);
        check({tag, " valid"}, {31'b0, ID_Valid}, {31'b0, m_valid});
        check({tag, " pc31"}, {31'b0, PC_31}, {31'b0, m_idpc[31]});
    endtask

    // one clock: drive inputs, check combinational outputs, advance model, check registers
    task automatic step(input string tag, input logic bt, input logic [31:0] tgt, input logic st,
                        input logic [2:0] src, input logic [31:0] rs, input logic irq);
        logic [31:0] seq, dest;
        logic        take;
        EX_BranchTaken = bt;
        EX_BranchTarget = tgt;
        Stall = st;
        PCSrc = src;
        ID_RsData = rs;
        IRQ_Raw = irq;
        #1;
        check({tag, " irq"}, {31'b0, IRQ}, {31'b0, irq & m_valid & ~m_idpc[31] & ~st});
        check({tag, " flush"}, {31'b0, Flush_IDEX}, {31'b0, bt});
        seq = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
        take = m_valid && !st && (src == 3'd2 || src == 3'd3 || src == 3'd4 || src == 3'd5);
        case (src)
            3'd4: dest = 32'h8000_0004;
            3'd5: dest = 32'h8000_0008;
            3'd2: dest = (m_idpc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            default: dest = rs;
        endcase
        if (bt || take) begin
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_idpc = m_pc;
            m_idpc4 = seq;
            m_pc = bt ? tgt : dest;
        end else if (!st) begin
            m_instr = mem_word(m_pc);
            m_valid = 1'b1;
            m_idpc = m_pc;
            m_idpc4 = seq;
            m_pc = seq;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b0);
    endtask

    task automatic branch(input string tag, input logic [31:0] tgt);
        step(tag, 1'b1, tgt, 1'b0, 3'b000, 32'h0, 1'b0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_regs("reset");
        check("reset irq", {31'b0, IRQ}, 32'h0);
        reset = 1'b1;
        idle("seq0");
        idle("seq1");
        idle("seq2");

        branch("to40", 32'h0000_0040);
        idle("fetch_j");
        step("jump", 1'b0, 32'h0, 1'b0, 3'b010, 32'h0, 1'b0);
        check("jump addr", IMem_Addr, 32'h0000_0400);
        idle("jump_bubble_out");
        check("jump target in id", ID_PC, 32'h0000_0400);

        step("br_vs_stall", 1'b1, 32'h0000_0200, 1'b1, 3'b011, 32'h1234_5678, 1'b0);
        idle("after_br");
        idle("load_seq");
        step("stall1", 1'b0, 32'h0, 1'b1, 3'b000, 32'h0, 1'b1);
        step("stall2", 1'b0, 32'h0, 1'b1, 3'b011, 32'h0, 1'b1);
        idle("resume");

        branch("to10", 32'h0000_0010);
        idle("fetch10");
        step("irq_user", 1'b0, 32'h0, 1'b0, 3'b100, 32'h0, 1'b1);
        check("illop addr", IMem_Addr, 32'h8000_0004);
        step("irq_bubble", 1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1);
        step("irq_kernel", 1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1);

        branch("to8020", 32'h8000_0020);
        idle("fetch8020");
        step("jr", 1'b0, 32'h0, 1'b0, 3'b011, 32'h0000_0050, 1'b0);
        idle("fetch50");
        check("jr pc31", {31'b0, PC_31}, 32'h0);

        branch("to7ffc", 32'h7FFF_FFFC);
        idle("wrap_lo");
        check("wrap lo", IMem_Addr, 32'h0000_0000);
        branch("toffc", 32'hFFFF_FFFC);
        idle("wrap_hi");
        check("wrap hi", IMem_Addr, 32'h8000_0000);

        idle("pre_midreset");
        PCSrc = 3'b010;
        reset = 1'b0;
        #1;
        model_reset();
        check_regs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle("post_reset");

        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(7) == 0, $urandom, $urandom_range(3) == 0,
                 3'($urandom_range(7)), $urandom, 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
